wb_write_arbiter: RTL
=====================

WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Parameters (name, default, meaning) SHALL be:
  DATA_W  32  register data width
  ADDR_W  8   register address width
  DEPTH   4   write-queue entries (power of two)
REQ-003 Ports (name  direction  width  meaning) SHALL be:
  clk         in   1              clock, all state on rising edge
  rst         in   1              synchronous active-high reset
  alu_valid   in   1              ALU result write request
  alu_ready   out  1              ALU request accepted this cycle
  alu_addr    in   ADDR_W         ALU destination register
  alu_data    in   DATA_W         ALU result
  ld_valid    in   1              load-unit write request
  ld_ready    out  1              load request accepted this cycle
  ld_addr     in   ADDR_W         load destination register
  ld_data     in   DATA_W         load data
  wr_stall    in   1              register-file write port unavailable
  addr_wr     out  ADDR_W         register-file write address (registered)
  data_in     out  DATA_W         register-file write data (registered)
  we          out  1              register-file write enable (registered)
  query_addr  in   ADDR_W         hazard-check address
  query_hit   out  1              write to query_addr pending (combinational)
  fifo_count  out  clog2(DEPTH)+1 queued entries

Function
REQ-004 Handshake: a request SHALL transfer on a rising edge where valid and ready are both 1; valid SHALL NOT depend on ready.
REQ-005 At most one request SHALL be accepted per cycle; x_ready = (fifo_count < DEPTH) and grant == x; no pass-through when full.
REQ-006 Arbitration SHALL be round-robin: both valid -> grant the source not granted last; one valid -> grant it; last_grant updates only on an accepted transfer.
REQ-007 An accepted request with destination address 0 SHALL complete its handshake and be discarded (not queued, fifo_count unchanged).
REQ-008 Accepted nonzero-address requests SHALL enter the FIFO in acceptance order; no coalescing of same-address writes.
REQ-009 Each cycle with fifo_count > 0 and wr_stall = 0 SHALL pop the head; on the following edge we=1, addr_wr/data_in = head entry, for exactly one cycle per entry.
REQ-010 Latency: request accepted at edge N into empty FIFO, wr_stall=0 -> we=1 with that entry during cycle after edge N+1; one write per cycle sustained throughput.
REQ-011 wr_stall = 1 SHALL suppress popping; we SHALL be 0 in the next cycle; queued entries retained.
REQ-012 When no pop occurs, we SHALL be 0 and addr_wr/data_in SHALL hold their previous values.
REQ-013 Simultaneous push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-014 query_hit SHALL be 1 iff query_addr != 0 and it matches any valid FIFO entry or the output stage while we=1.

Reset
REQ-015 rst=1 at an edge SHALL flush the FIFO (fifo_count=0), set we=0, addr_wr=0, data_in=0, last_grant=ALU (load wins first tie); pending entries lost.
REQ-016 While rst=1, alu_ready and ld_ready SHALL be 0; reset mid-stream SHALL discard any request presented in that cycle.

Verification
REQ-017 Single ALU write addr 1 data A5A5A5A5, wr_stall=0 -> one cycle we=1, addr_wr=01, data_in=A5A5A5A5 two edges after valid raised; three_port_ram port A then reads A5A5A5A5.
REQ-018 ALU and load both valid every cycle (addrs 2/3) from reset -> accept order ld,alu,ld,alu; we sequence matches; fifo_count never exceeds 1.
REQ-019 wr_stall=1, push 5 writes (addrs 4..8) -> first 4 accepted, fifo_count=4, both ready=0; release stall -> 4 writes on consecutive cycles in order, then 5th.
REQ-020 Write addr 0 data FFFFFFFF -> handshake completes, we never asserted, fifo_count stays 0; register 0 reads 0.
REQ-021 Stall with entry addr 9 queued, query_addr=9 -> query_hit=1; query_addr=0 -> 0; after entry written and we drops -> 0.
REQ-022 rst asserted with 3 queued entries -> next cycle fifo_count=0, we=0, addr_wr=0, data_in=0; none of the 3 writes appear.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// Round-robin arbiter merging ALU and load-unit register writes into a small FIFO
// that drains one write per cycle to a registered register-file write port.
module wb_write_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [ADDR_W-1:0]       alu_addr,
    input  logic [DATA_W-1:0]       alu_data,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [ADDR_W-1:0]       ld_addr,
    input  logic [DATA_W-1:0]       ld_data,
    input  logic                    wr_stall,
    output logic [ADDR_W-1:0]       addr_wr,
    output logic [DATA_W-1:0]       data_in,
    output logic                    we,
    input  logic [ADDR_W-1:0]       query_addr,
    output logic                    query_hit,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned EntW = ADDR_W + DATA_W;

    logic [EntW-1:0]   mem_q [DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              last_alu_q, last_alu_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_wr_q, addr_wr_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;

    logic              grant_alu, grant_ld;
    logic              space, accept, push, pop;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              fifo_hit;
    logic [PtrW:0]     slot;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // On a tie the source that did not win last time gets the grant.
    always_comb begin
        grant_alu = 1'b0;
        grant_ld  = 1'b0;
        if (alu_valid && ld_valid) begin
            grant_ld  = last_alu_q;
            grant_alu = !last_alu_q;
        end else begin
            grant_alu = alu_valid;
            grant_ld  = ld_valid;
        end
    end

    assign space     = count_q < CntW'(DEPTH);
    assign alu_ready = !rst && space && grant_alu;
    assign ld_ready  = !rst && space && grant_ld;
    assign accept    = alu_ready || ld_ready;
    assign in_addr   = grant_alu ? alu_addr : ld_addr;
    assign in_data   = grant_alu ? alu_data : ld_data;
    assign push      = accept && (in_addr != '0);
    assign pop       = (count_q != '0) && !wr_stall;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q + CntW'(push) - CntW'(pop);
        last_alu_d = last_alu_q;
        we_d       = pop;
        addr_wr_d  = addr_wr_q;
        data_in_d  = data_in_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d  = ptr_inc(rd_ptr_q);
            addr_wr_d = mem_q[rd_ptr_q][EntW-1:DATA_W];
            data_in_d = mem_q[rd_ptr_q][DATA_W-1:0];
        end
        if (accept) begin
            last_alu_d = grant_alu;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            last_alu_q <= 1'b1;
            we_q       <= 1'b0;
            addr_wr_q  <= '0;
            data_in_q  <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            last_alu_q <= last_alu_d;
            we_q       <= we_d;
            addr_wr_q  <= addr_wr_d;
            data_in_q  <= data_in_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_addr, in_data};
        end
    end

    // Scan occupied slots starting from the head for a pending write to query_addr.
    always_comb begin
        fifo_hit = 1'b0;
        slot     = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            slot = {1'b0, rd_ptr_q} + (PtrW + 1)'(k);
            if (slot >= (PtrW + 1)'(DEPTH)) begin
                slot = slot - (PtrW + 1)'(DEPTH);
            end
            if ((CntW'(k) < count_q) && (mem_q[slot[PtrW-1:0]][EntW-1:DATA_W] == query_addr)) begin
                fifo_hit = 1'b1;
            end
        end
    end

    assign query_hit  = (query_addr != '0) && (fifo_hit || (we_q && (addr_wr_q == query_addr)));
    assign we         = we_q;
    assign addr_wr    = addr_wr_q;
    assign data_in    = data_in_q;
    assign fifo_count = count_q;

endmodule
